alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 25 ++
 rtl/operand_fwd.sv | 32 +++
 rtl/alu_issue_stage.sv | 107 ++++++++++
 tb/tb_alu_issue_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants, opcode type and issue-entry struct
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    // {funct7[5], funct3} encoding
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;

    typedef struct packed {
        logic [31:0] Ain;
        logic [31:0] Bin;
        alu_op_t     ALUop;
        logic [4:0]  rd;
    } issue_entry_t;

endpackage

// File: rtl/operand_fwd.sv
// rtl/operand_fwd.sv - one source operand bypass mux; active only with ALU_ISSUE_FORWARD_EN
module operand_fwd (
    input  logic [4:0]  idx,
    input  logic [31:0] rs_data,
    input  logic        fwd_ex_valid,
    input  logic [4:0]  fwd_ex_rd,
    input  logic [31:0] fwd_ex_data,
    input  logic        fwd_mem_valid,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    output logic [31:0] data
);

`ifdef ALU_ISSUE_FORWARD_EN
    // x0 is hardwired, so index 0 must never pick up a bypass value
    always_comb begin
        data = rs_data;
        if (idx != 5'd0) begin
            if (fwd_ex_valid && fwd_ex_rd == idx)
                data = fwd_ex_data;
            else if (fwd_mem_valid && fwd_mem_rd == idx)
                data = fwd_mem_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{idx, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                          fwd_mem_valid, fwd_mem_rd, fwd_mem_data};
    assign data = rs_data;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-entry skid-buffered ALU issue stage (bypass via ALU_ISSUE_FORWARD_EN)
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        use_pc,
    input  logic        use_imm,
    input  logic [3:0]  alu_op_in,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    input  logic [4:0]  rd_idx,
    input  logic        fwd_ex_valid,
    input  logic        fwd_mem_valid,
    input  logic [4:0]  fwd_ex_rd,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_ex_data,
    input  logic [31:0] fwd_mem_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Ain,
    output logic [31:0] Bin,
    output logic [3:0]  ALUop,
    output logic [4:0]  rd_out,
    output logic [15:0] stall_cnt
);

    import alu_pkg::*;

    logic         main_valid;
    logic         skid_valid;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    issue_entry_t new_entry;
    logic [31:0]  fwd_a;
    logic [31:0]  fwd_b;
    logic         accept;
    logic         xfer;

    operand_fwd u_fwd_a (
        .idx(rs1_idx), .rs_data(rs1_data),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .data(fwd_a)
    );

    operand_fwd u_fwd_b (
        .idx(rs2_idx), .rs_data(rs2_data),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .data(fwd_b)
    );

    assign new_entry = '{Ain:   use_pc  ? pc  : fwd_a,
                         Bin:   use_imm ? imm : fwd_b,
                         ALUop: alu_op_in,
                         rd:    rd_idx};

    assign accept = in_valid && in_ready;
    assign xfer   = main_valid && out_ready;

    // in_ready tracks !skid_valid as a register so it never sees out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (xfer && skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!main_valid || xfer) begin
            main_valid <= accept;
            if (accept)
                main_q <= new_entry;
        end else if (accept) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (main_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign out_valid = main_valid;
    assign Ain       = main_q.Ain;
    assign Bin       = main_q.Bin;
    assign ALUop     = main_q.ALUop;
    assign rd_out    = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        use_pc, use_imm;
    logic [3:0]  alu_op_in;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        fwd_ex_valid, fwd_mem_valid;
    logic [4:0]  fwd_ex_rd, fwd_mem_rd;
    logic [31:0] fwd_ex_data, fwd_mem_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Ain, Bin;
    logic [3:0]  ALUop;
    logic [4:0]  rd_out;
    logic [15:0] stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .use_pc(use_pc), .use_imm(use_imm), .alu_op_in(alu_op_in),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .fwd_ex_valid(fwd_ex_valid), .fwd_mem_valid(fwd_mem_valid),
        .fwd_ex_rd(fwd_ex_rd), .fwd_mem_rd(fwd_mem_rd),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .rd_out(rd_out), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [4:0] rd);
        in_valid  = v;
        rs1_data  = a;
        rs2_data  = b;
        alu_op_in = op;
        rd_idx    = rd;
        rs1_idx   = 5'd1;
        rs2_idx   = 5'd2;
        use_pc    = 1'b0;
        use_imm   = 1'b0;
    endtask

    task automatic test_reset();
        compared += 7;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (Ain !== 32'd0) begin mismatched++; $display("FAIL reset_Ain got %h want 0", Ain); end
        if (Bin !== 32'd0) begin mismatched++; $display("FAIL reset_Bin got %h want 0", Bin); end
        if (ALUop !== 4'd0) begin mismatched++; $display("FAIL reset_ALUop got %h want 0", ALUop); end
        if (rd_out !== 5'd0) begin mismatched++; $display("FAIL reset_rd_out got %h want 0", rd_out); end
        if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] bv [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        logic [3:0]  ov [4] = '{4'b0000, 4'b1000, 4'b0100, 4'b1101};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, av[k], bv[k], ov[k], 5'(k + 3));
            step();
            compared += 5;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid); end
            if (Ain !== av[k]) begin mismatched++; $display("FAIL b2b_Ain[%0d] got %h want %h", k, Ain, av[k]); end
            if (Bin !== bv[k]) begin mismatched++; $display("FAIL b2b_Bin[%0d] got %h want %h", k, Bin, bv[k]); end
            if (ALUop !== ov[k]) begin mismatched++; $display("FAIL b2b_ALUop[%0d] got %h want %h", k, ALUop, ov[k]); end
            if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_in_ready[%0d] got %b want 1", k, in_ready); end
        end
        in_valid = 1'b0;
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_in(1'b1, 32'h100, 32'h0, 4'd0, 5'd10);
        step();
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stall_ready1 got %b want 1", in_ready); end
        set_in(1'b1, 32'h101, 32'h0, 4'd0, 5'd11);
        step();
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ready2 got %b want 0", in_ready); end
        set_in(1'b1, 32'h102, 32'h0, 4'd0, 5'd12);
        step();
        step();
        compared += 3;
        if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
        if (Ain !== 32'h100) begin mismatched++; $display("FAIL stall_hold_Ain got %h want 100", Ain); end
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ready3 got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        compared += 2;
        if (Ain !== 32'h101 || rd_out !== 5'd11) begin mismatched++; $display("FAIL stall_order1 got %h/%0d want 101/11", Ain, rd_out); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stall_ready4 got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        compared++;
        if (Ain !== 32'h102 || rd_out !== 5'd12) begin mismatched++; $display("FAIL stall_order2 got %h/%0d want 102/12", Ain, rd_out); end
        step();
        compared += 2;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_drain got %b want 0", out_valid); end
        if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL stall_cnt_after got %0d want 3", stall_cnt); end
    endtask

    task automatic test_forward();
        logic [31:0] exp_a, exp_b;
        out_ready = 1'b1;
        set_in(1'b1, 32'h55, 32'h66, 4'd0, 5'd7);
        rs1_idx = 5'd5; rs2_idx = 5'd5;
        fwd_ex_valid = 1'b1;  fwd_ex_rd = 5'd5;  fwd_ex_data = 32'hAAAA0000;
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h1234;
`ifdef ALU_ISSUE_FORWARD_EN
        exp_a = 32'hAAAA0000; exp_b = 32'hAAAA0000;
`else
        exp_a = 32'h55; exp_b = 32'h66;
`endif
        step();
        compared += 2;
        if (Ain !== exp_a) begin mismatched++; $display("FAIL fwd_ex_prio_A got %h want %h", Ain, exp_a); end
        if (Bin !== exp_b) begin mismatched++; $display("FAIL fwd_ex_prio_B got %h want %h", Bin, exp_b); end
        fwd_ex_valid = 1'b0;
`ifdef ALU_ISSUE_FORWARD_EN
        exp_a = 32'h1234;
`else
        exp_a = 32'h55;
`endif
        step();
        compared++;
        if (Ain !== exp_a) begin mismatched++; $display("FAIL fwd_mem_A got %h want %h", Ain, exp_a); end
        rs1_idx = 5'd0; fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_mem_rd = 5'd0;
        step();
        compared++;
        if (Ain !== 32'h55) begin mismatched++; $display("FAIL fwd_x0_A got %h want 00000055", Ain); end
        in_valid = 1'b0; fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;
        step();
    endtask

    task automatic test_select();
        out_ready = 1'b1;
        set_in(1'b1, 32'h55, 32'h66, 4'b0000, 5'd9);
        use_pc = 1'b1; pc = 32'h100; use_imm = 1'b1; imm = 32'hFFFFFFFC;
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'hDEAD;
        step();
        compared += 3;
        if (Ain !== 32'h100) begin mismatched++; $display("FAIL select_A got %h want 00000100", Ain); end
        if (Bin !== 32'hFFFFFFFC) begin mismatched++; $display("FAIL select_B got %h want fffffffc", Bin); end
        if (ALUop !== 4'b0000) begin mismatched++; $display("FAIL select_op got %h want 0", ALUop); end
        in_valid = 1'b0; fwd_ex_valid = 1'b0; use_pc = 1'b0; use_imm = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 32'h200, 32'h0, 4'd0, 5'd20);
        step();
        set_in(1'b1, 32'h201, 32'h0, 4'd0, 5'd21);
        step();
        set_in(1'b1, 32'h202, 32'h0, 4'd0, 5'd22);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        compared += 3;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_full_ready got %b want 1", in_ready); end
        if (stall_cnt !== 16'd5) begin mismatched++; $display("FAIL flush_stall_cnt got %0d want 5", stall_cnt); end
        set_in(1'b1, 32'h203, 32'h0, 4'd0, 5'd23);
        step();
        set_in(1'b1, 32'h204, 32'h0, 4'd0, 5'd24);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        compared += 2;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_accept_valid got %b want 0", out_valid); end
        if (stall_cnt !== 16'd6) begin mismatched++; $display("FAIL flush_stall_cnt2 got %0d want 6", stall_cnt); end
        out_ready = 1'b1;
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_no_ghost got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h300, 32'h301, 4'b0111, 5'd30);
        step();
        set_in(1'b1, 32'h310, 32'h311, 4'b0110, 5'd31);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        compared += 7;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
        if (Ain !== 32'd0) begin mismatched++; $display("FAIL arst_Ain got %h want 0", Ain); end
        if (Bin !== 32'd0) begin mismatched++; $display("FAIL arst_Bin got %h want 0", Bin); end
        if (ALUop !== 4'd0) begin mismatched++; $display("FAIL arst_ALUop got %h want 0", ALUop); end
        if (rd_out !== 5'd0) begin mismatched++; $display("FAIL arst_rd_out got %h want 0", rd_out); end
        if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL arst_stall_cnt got %h want 0", stall_cnt); end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 32'h320, 32'h321, 4'b0010, 5'd3);
        step();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || Ain !== 32'h320 || rd_out !== 5'd3) begin
            mismatched++; $display("FAIL arst_first_accept got %b/%h/%0d want 1/320/3", out_valid, Ain, rd_out);
        end
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL arst_no_stale got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 4'd0, 5'd0);
        imm = 32'h0; pc = 32'h0;
        fwd_ex_valid = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h0;
        fwd_mem_valid = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_back_to_back();
        test_stall();
        test_forward();
        test_select();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
